// File: rtl/lc3_decode_pkg.sv
// lc3_decode_pkg: opcodes, control encodings and E_control layout for the LC3 decode stage
package lc3_decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;

    function automatic logic is_illegal(opcode_e op);
        return op inside {OP_JSR, OP_RTI, OP_RES, OP_TRAP};
    endfunction

endpackage

// File: rtl/lc3_decode_ctrl_lut.sv
// lc3_decode_ctrl_lut: combinational opcode -> {E, W, Mem} control decoder
module lc3_decode_ctrl_lut
    import lc3_decode_pkg::*;
(
    input  opcode_e    op,
    input  logic       imm,
    output e_ctrl_t    e_ctrl,
    output logic [1:0] w_ctrl,
    output logic       mem_ctrl
);

    always_comb begin
        e_ctrl   = '0;
        w_ctrl   = W_ALU;
        mem_ctrl = 1'b0;
        case (op)
            OP_ADD, OP_AND: begin
                e_ctrl.alu_control = (op == OP_AND) ? ALU_AND : ALU_ADD;
                e_ctrl.op2select   = ~imm;
            end
            OP_NOT: e_ctrl.alu_control = ALU_NOT;
            OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: begin
                e_ctrl.pcselect1 = PCSEL1_OFF9;
                e_ctrl.pcselect2 = 1'b1;
                w_ctrl           = (op inside {OP_LD, OP_LDI}) ? W_MEM : (op == OP_LEA) ? W_PC : W_ALU;
                mem_ctrl         = op inside {OP_LDI, OP_STI};
            end
            OP_JMP: e_ctrl.pcselect1 = PCSEL1_ZERO;
            OP_LDR, OP_STR: begin
                e_ctrl.pcselect1 = PCSEL1_OFF6;
                w_ctrl           = (op == OP_LDR) ? W_MEM : W_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage: registered LC3 decode stage; LC3_DECODE_ILLEGAL_CHK_EN adds illegal_op flag
module lc3_decode_stage
    import lc3_decode_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_decode,
    input  logic [DATA_W-1:0] dout,
    input  logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] npc_out,
    output logic [5:0]        E_control,
    output logic [1:0]        W_control,
    output logic              Mem_control,
    output logic              decode_valid
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
    ,
    output logic              illegal_op
`endif
);

    if (DATA_W != 16) begin : g_bad_width
        $fatal(1, "lc3_decode_stage supports only DATA_W=16");
    end

    opcode_e    op;
    e_ctrl_t    e_next;
    logic [1:0] w_next;
    logic       mem_next;

    assign op = opcode_e'(dout[15:12]);

    lc3_decode_ctrl_lut u_lut (
        .op       (op),
        .imm      (dout[5]),
        .e_ctrl   (e_next),
        .w_ctrl   (w_next),
        .mem_ctrl (mem_next)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            IR           <= '0;
            npc_out      <= '0;
            E_control    <= '0;
            W_control    <= '0;
            Mem_control  <= 1'b0;
            decode_valid <= 1'b0;
        end else begin
            decode_valid <= enable_decode;
            if (enable_decode) begin
                IR          <= dout;
                npc_out     <= npc_in;
                E_control   <= e_next;
                W_control   <= w_next;
                Mem_control <= mem_next;
            end
        end
    end

`ifdef LC3_DECODE_ILLEGAL_CHK_EN
    always_ff @(posedge clock) begin
        if (!reset) illegal_op <= 1'b0;
        else if (enable_decode) illegal_op <= is_illegal(op);
    end
`ifndef SYNTHESIS
`ifdef LC3_DECODE_STRICT
    // Strict simulation mode: an unsupported opcode must never reach execute as valid
    a_no_illegal: assert property (@(posedge clock) disable iff (!reset) !(illegal_op && decode_valid));
`endif
`endif
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// tb_lc3_decode_stage: directed plus random stimulus against a field-rule reference model
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_decode = 1'b0;
    logic [15:0] dout = '0;
    logic [15:0] npc_in = '0;
    logic [15:0] IR, npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control, decode_valid;
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
    logic        illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m_ir, m_npc;
    logic [5:0]  m_e;
    logic [1:0]  m_w;
    logic        m_mem, m_valid, m_ill;

    lc3_decode_stage #(.DATA_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .dout          (dout),
        .npc_in        (npc_in),
        .IR            (IR),
        .npc_out       (npc_out),
        .E_control     (E_control),
        .W_control     (W_control),
        .Mem_control   (Mem_control),
        .decode_valid  (decode_valid)
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_ctrl(input logic [15:0] d);
        int op = int'(d[15:12]);
        bit pc_rel = op inside {0, 2, 3, 10, 11, 14};
        logic [1:0] alu = (op == 9) ? 2'd2 : (op == 5) ? 2'd1 : 2'd0;
        logic [1:0] p1  = pc_rel ? 2'd1 : (op == 12) ? 2'd3 : (op inside {6, 7}) ? 2'd2 : 2'd0;
        logic op2 = (op inside {1, 5}) && !d[5];
        logic [1:0] w = (op inside {2, 6, 10}) ? 2'd1 : (op == 14) ? 2'd2 : 2'd0;
        logic mem = op inside {10, 11};
        return {alu, p1, pc_rel, op2, w, mem};
    endfunction

    task automatic step(input logic rst, input logic en, input logic [15:0] d, input logic [15:0] npc);
        @(negedge clock);
        reset = rst;
        enable_decode = en;
        dout = d;
        npc_in = npc;
        @(posedge clock);
        if (!rst) begin
            {m_ir, m_npc, m_e, m_w, m_mem, m_valid, m_ill} = '0;
        end else begin
            m_valid = en;
            if (en) begin
                m_ir = d;
                m_npc = npc;
                {m_e, m_w, m_mem} = ref_ctrl(d);
                m_ill = d[15:12] inside {4'h4, 4'h8, 4'hD, 4'hF};
            end
        end
        #1;
        check("IR", 32'(IR), 32'(m_ir));
        check("npc_out", 32'(npc_out), 32'(m_npc));
        check("E_control", 32'(E_control), 32'(m_e));
        check("W_control", 32'(W_control), 32'(m_w));
        check("Mem_control", 32'(Mem_control), 32'(m_mem));
        check("decode_valid", 32'(decode_valid), 32'(m_valid));
`ifdef LC3_DECODE_ILLEGAL_CHK_EN
        check("illegal_op", 32'(illegal_op), 32'(m_ill));
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1283, 16'h3001);
        check("reset_E_const", 32'(E_control), 32'h0);
        step(1'b1, 1'b1, 16'h1283, 16'h3001);
        check("add_reg_E_const", 32'(E_control), 32'b000001);
        step(1'b1, 1'b1, 16'h12A5, 16'h3002);
        check("add_imm_E_const", 32'(E_control), 32'b000000);
        step(1'b1, 1'b1, 16'h927F, 16'h3003);
        check("not_E_const", 32'(E_control), 32'b100000);
        step(1'b1, 1'b1, 16'h6283, 16'h3004);
        check("ldr_E_const", 32'(E_control), 32'b001000);
        step(1'b1, 1'b1, 16'hA205, 16'h3005);
        check("ldi_E_const", 32'(E_control), 32'b000110);
        check("ldi_mem_const", 32'(Mem_control), 32'h1);
        step(1'b1, 1'b1, 16'hE005, 16'h3006);
        check("lea_W_const", 32'(W_control), 32'h2);
        step(1'b1, 1'b1, 16'hC1C0, 16'h3007);
        check("jmp_E_const", 32'(E_control), 32'b001100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        check("hold_IR_const", 32'(IR), 32'hC1C0);
        step(1'b1, 1'b1, 16'hF025, 16'hFFFF);
        check("trap_npc_const", 32'(npc_out), 32'hFFFF);
        step(1'b0, 1'b1, 16'h1283, 16'h3009);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
